// File: rtl/vga_timing_gen.sv
// Parameterised VGA raster timing generator: pixel/line counters with registered,
// mutually aligned region flags, polarity-applied syncs, display enable and start strobes.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 800,
  parameter int unsigned H_FRONT   = 40,
  parameter int unsigned H_SYNC    = 128,
  parameter int unsigned H_BACK    = 88,
  parameter int unsigned V_VISIBLE = 600,
  parameter int unsigned V_FRONT   = 1,
  parameter int unsigned V_SYNC    = 4,
  parameter int unsigned V_BACK    = 23,
  parameter bit          HSYNC_POL = 1'b1,
  parameter bit          VSYNC_POL = 1'b1,
  parameter int unsigned HW        = 11,
  parameter int unsigned VW        = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          h_visible_area,
  output logic          h_front_porch,
  output logic          h_sync_pulse,
  output logic          h_back_porch,
  output logic          v_visible_area,
  output logic          v_front_porch,
  output logic          v_sync_pulse,
  output logic          v_back_porch,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          line_start,
  output logic          frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Region start columns/lines; all are strictly below the totals so they fit HW/VW.
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_FP_START = HW'(H_VISIBLE);
  localparam logic [HW-1:0] H_SP_START = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] H_BP_START = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_FP_START = VW'(V_VISIBLE);
  localparam logic [VW-1:0] V_SP_START = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] V_BP_START = VW'(V_VISIBLE + V_FRONT + V_SYNC);

  if (H_VISIBLE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_VISIBLE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
      64'(H_TOTAL) > (64'd1 << HW) || 64'(V_TOTAL) > (64'd1 << VW)) begin : g_bad_params
    $error("vga_timing_gen: illegal region sizes or counter widths");
  end

  logic [HW-1:0] h_next;
  logic [VW-1:0] v_next;
  logic          line_wrap;
  logic          frame_wrap;
  logic          h_vis_next, h_fp_next, h_sp_next, h_bp_next;
  logic          v_vis_next, v_fp_next, v_sp_next, v_bp_next;

  // Next counter values; the wrap is detected before incrementing so no overflow occurs.
  always_comb begin
    h_next     = hcount;
    v_next     = vcount;
    line_wrap  = 1'b0;
    frame_wrap = 1'b0;
    if (ce) begin
      if (hcount == H_LAST) begin
        h_next    = '0;
        line_wrap = 1'b1;
        if (vcount == V_LAST) begin
          v_next     = '0;
          frame_wrap = 1'b1;
        end else begin
          v_next = vcount + VW'(1);
        end
      end else begin
        h_next = hcount + HW'(1);
      end
    end
  end

  // Flags decode the next position so they register in step with the counters.
  always_comb begin
    h_vis_next = (h_next < H_FP_START);
    h_fp_next  = (h_next >= H_FP_START) && (h_next < H_SP_START);
    h_sp_next  = (h_next >= H_SP_START) && (h_next < H_BP_START);
    h_bp_next  = (h_next >= H_BP_START);
    v_vis_next = (v_next < V_FP_START);
    v_fp_next  = (v_next >= V_FP_START) && (v_next < V_SP_START);
    v_sp_next  = (v_next >= V_SP_START) && (v_next < V_BP_START);
    v_bp_next  = (v_next >= V_BP_START);
  end

  // Reset parks the raster on the last pixel so the first enabled edge lands on (0,0).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcount         <= H_LAST;
      vcount         <= V_LAST;
      h_visible_area <= 1'b0;
      h_front_porch  <= 1'b0;
      h_sync_pulse   <= 1'b0;
      h_back_porch   <= 1'b1;
      v_visible_area <= 1'b0;
      v_front_porch  <= 1'b0;
      v_sync_pulse   <= 1'b0;
      v_back_porch   <= 1'b1;
      hsync          <= ~HSYNC_POL;
      vsync          <= ~VSYNC_POL;
      de             <= 1'b0;
      line_start     <= 1'b0;
      frame_start    <= 1'b0;
    end else begin
      hcount         <= h_next;
      vcount         <= v_next;
      h_visible_area <= h_vis_next;
      h_front_porch  <= h_fp_next;
      h_sync_pulse   <= h_sp_next;
      h_back_porch   <= h_bp_next;
      v_visible_area <= v_vis_next;
      v_front_porch  <= v_fp_next;
      v_sync_pulse   <= v_sp_next;
      v_back_porch   <= v_bp_next;
      hsync          <= h_sp_next ? HSYNC_POL : ~HSYNC_POL;
      vsync          <= v_sp_next ? VSYNC_POL : ~VSYNC_POL;
      de             <= h_vis_next & v_vis_next;
      line_start     <= line_wrap;
      frame_start    <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen with a reduced 16x8 raster; a second instance
// with inverted sync polarity shares clock, reset and ce.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0;
  int   checks = 0;
  int   failures = 0;

  // Expected raster position and strobes.
  int   eh = 15;
  int   ev = 7;
  logic els = 1'b0;
  logic efs = 1'b0;

  logic [3:0] a_hcount, b_hcount;
  logic [2:0] a_vcount, b_vcount;
  logic a_hv, a_hf, a_hs, a_hb, a_vv, a_vf, a_vs, a_vb;
  logic b_hv, b_hf, b_hs, b_hb, b_vv, b_vf, b_vs, b_vb;
  logic a_hsync, a_vsync, a_de, a_ls, a_fs;
  logic b_hsync, b_vsync, b_de, b_ls, b_fs;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .HW(4), .VW(3)
  ) dut_a (
    .clk(clk), .reset(rst_n), .ce(ce),
    .hcount(a_hcount), .vcount(a_vcount),
    .h_visible_area(a_hv), .h_front_porch(a_hf), .h_sync_pulse(a_hs), .h_back_porch(a_hb),
    .v_visible_area(a_vv), .v_front_porch(a_vf), .v_sync_pulse(a_vs), .v_back_porch(a_vb),
    .hsync(a_hsync), .vsync(a_vsync), .de(a_de),
    .line_start(a_ls), .frame_start(a_fs)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .HW(4), .VW(3)
  ) dut_b (
    .clk(clk), .reset(rst_n), .ce(ce),
    .hcount(b_hcount), .vcount(b_vcount),
    .h_visible_area(b_hv), .h_front_porch(b_hf), .h_sync_pulse(b_hs), .h_back_porch(b_hb),
    .v_visible_area(b_vv), .v_front_porch(b_vf), .v_sync_pulse(b_vs), .v_back_porch(b_vb),
    .hsync(b_hsync), .vsync(b_vsync), .de(b_de),
    .line_start(b_ls), .frame_start(b_fs)
  );

  // Hand-derived region maps, ordered {visible, front, sync, back}.
  function automatic logic [3:0] h_regions(input int h);
    if (h < 8)  return 4'b1000;
    if (h < 10) return 4'b0100;
    if (h < 13) return 4'b0010;
    return 4'b0001;
  endfunction

  function automatic logic [3:0] v_regions(input int v);
    if (v < 4) return 4'b1000;
    if (v < 5) return 4'b0100;
    if (v < 7) return 4'b0010;
    return 4'b0001;
  endfunction

  task automatic model_step(input logic c);
    if (c) begin
      els = (eh == 15);
      efs = (eh == 15) && (ev == 7);
      if (eh == 15) begin
        eh = 0;
        ev = (ev == 7) ? 0 : ev + 1;
      end else begin
        eh = eh + 1;
      end
    end else begin
      els = 1'b0;
      efs = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ce    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({a_hcount, a_vcount} !== {4'd15, 3'd7}) begin
      failures++;
      $display("FAIL reset_pos: got %h exp %h", {a_hcount, a_vcount}, {4'd15, 3'd7});
    end
    checks++;
    if ({a_hv, a_hf, a_hs, a_hb, a_vv, a_vf, a_vs, a_vb} !== 8'b0001_0001) begin
      failures++;
      $display("FAIL reset_flags: got %b exp %b", {a_hv, a_hf, a_hs, a_hb, a_vv, a_vf, a_vs, a_vb}, 8'b0001_0001);
    end
    checks++;
    if ({a_hsync, a_vsync, a_de, a_ls, a_fs} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_outs: got %b exp %b", {a_hsync, a_vsync, a_de, a_ls, a_fs}, 5'b00000);
    end
    checks++;
    if ({b_hsync, b_vsync} !== 2'b11) begin
      failures++;
      $display("FAIL reset_neg_pol: got %b exp %b", {b_hsync, b_vsync}, 2'b11);
    end
  endtask

  task automatic test_first_edge();
    rst_n = 1'b1;
    ce    = 1'b1;
    @(posedge clk);
    #1;
    model_step(1'b1);
    checks++;
    if ({a_hcount, a_vcount, a_fs, a_ls, a_de} !== {4'd0, 3'd0, 3'b111}) begin
      failures++;
      $display("FAIL first_edge: got %h exp %h", {a_hcount, a_vcount, a_fs, a_ls, a_de}, {4'd0, 3'd0, 3'b111});
    end
  endtask

  task automatic test_frame();
    int de_cnt = 0;
    for (int i = 0; i < 128; i++) begin
      checks++;
      if ({a_hcount, a_vcount} !== {4'(eh), 3'(ev)}) begin
        failures++;
        $display("FAIL frame_pos[%0d]: got %h exp %h", i, {a_hcount, a_vcount}, {4'(eh), 3'(ev)});
      end
      checks++;
      if ({a_hv, a_hf, a_hs, a_hb, a_vv, a_vf, a_vs, a_vb} !== {h_regions(eh), v_regions(ev)}) begin
        failures++;
        $display("FAIL frame_flags[%0d]: got %b exp %b", i, {a_hv, a_hf, a_hs, a_hb, a_vv, a_vf, a_vs, a_vb}, {h_regions(eh), v_regions(ev)});
      end
      checks++;
      if ({a_hsync, a_vsync, a_de} !== {(eh >= 10 && eh <= 12), (ev >= 5 && ev <= 6), (eh < 8 && ev < 4)}) begin
        failures++;
        $display("FAIL frame_sync_de[%0d]: got %b exp %b", i, {a_hsync, a_vsync, a_de},
                 {(eh >= 10 && eh <= 12), (ev >= 5 && ev <= 6), (eh < 8 && ev < 4)});
      end
      checks++;
      if ({a_ls, a_fs} !== {els, efs}) begin
        failures++;
        $display("FAIL frame_strobes[%0d]: got %b exp %b", i, {a_ls, a_fs}, {els, efs});
      end
      checks++;
      if ({b_hsync, b_vsync} !== {!(eh >= 10 && eh <= 12), !(ev >= 5 && ev <= 6)}) begin
        failures++;
        $display("FAIL frame_neg_pol[%0d]: got %b exp %b", i, {b_hsync, b_vsync},
                 {!(eh >= 10 && eh <= 12), !(ev >= 5 && ev <= 6)});
      end
      de_cnt += int'(a_de);
      @(posedge clk);
      #1;
      model_step(1'b1);
    end
    checks++;
    if (de_cnt !== 32) begin
      failures++;
      $display("FAIL de_count: got %0d exp %0d", de_cnt, 32);
    end
    checks++;
    if ({a_fs, a_hcount, a_vcount} !== {1'b1, 4'd0, 3'd0}) begin
      failures++;
      $display("FAIL frame_recur: got %h exp %h", {a_fs, a_hcount, a_vcount}, {1'b1, 4'd0, 3'd0});
    end
  endtask

  task automatic test_ce_toggle();
    logic c;
    for (int i = 0; i < 260; i++) begin
      checks++;
      if ({a_hcount, a_vcount} !== {4'(eh), 3'(ev)}) begin
        failures++;
        $display("FAIL ce_pos[%0d]: got %h exp %h", i, {a_hcount, a_vcount}, {4'(eh), 3'(ev)});
      end
      checks++;
      if ({a_hv, a_hf, a_hs, a_hb, a_vv, a_vf, a_vs, a_vb, a_hsync, a_vsync, a_de} !==
          {h_regions(eh), v_regions(ev), (eh >= 10 && eh <= 12), (ev >= 5 && ev <= 6), (eh < 8 && ev < 4)}) begin
        failures++;
        $display("FAIL ce_hold_outs[%0d]: got %b exp %b", i,
                 {a_hv, a_hf, a_hs, a_hb, a_vv, a_vf, a_vs, a_vb, a_hsync, a_vsync, a_de},
                 {h_regions(eh), v_regions(ev), (eh >= 10 && eh <= 12), (ev >= 5 && ev <= 6), (eh < 8 && ev < 4)});
      end
      checks++;
      if ({a_ls, a_fs} !== {els, efs}) begin
        failures++;
        $display("FAIL ce_strobes[%0d]: got %b exp %b", i, {a_ls, a_fs}, {els, efs});
      end
      c  = (i % 2 == 0);
      ce = c;
      @(posedge clk);
      #1;
      model_step(c);
    end
    ce = 1'b1;
  endtask

  task automatic test_reset_mid();
    for (int n = 0; n < 300 && !(eh == 5 && ev == 2); n++) begin
      @(posedge clk);
      #1;
      model_step(1'b1);
    end
    checks++;
    if ({a_hcount, a_vcount} !== {4'd5, 3'd2}) begin
      failures++;
      $display("FAIL mid_reach: got %h exp %h", {a_hcount, a_vcount}, {4'd5, 3'd2});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_hcount, a_vcount, a_hv, a_hf, a_hs, a_hb, a_vv, a_vf, a_vs, a_vb, a_hsync, a_vsync, a_de, a_ls, a_fs}
        !== {4'd15, 3'd7, 8'b0001_0001, 5'b00000}) begin
      failures++;
      $display("FAIL mid_async_reset: got %h exp %h",
               {a_hcount, a_vcount, a_hv, a_hf, a_hs, a_hb, a_vv, a_vf, a_vs, a_vb, a_hsync, a_vsync, a_de, a_ls, a_fs},
               {4'd15, 3'd7, 8'b0001_0001, 5'b00000});
    end
    checks++;
    if ({b_hsync, b_vsync} !== 2'b11) begin
      failures++;
      $display("FAIL mid_reset_neg_pol: got %b exp %b", {b_hsync, b_vsync}, 2'b11);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({a_hcount, a_vcount} !== {4'd15, 3'd7}) begin
      failures++;
      $display("FAIL mid_reset_hold: got %h exp %h", {a_hcount, a_vcount}, {4'd15, 3'd7});
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    eh = 0;
    ev = 0;
    checks++;
    if ({a_hcount, a_vcount, a_fs, a_ls, a_de} !== {4'd0, 3'd0, 3'b111}) begin
      failures++;
      $display("FAIL mid_restart: got %h exp %h", {a_hcount, a_vcount, a_fs, a_ls, a_de}, {4'd0, 3'd0, 3'b111});
    end
  endtask

  initial begin
    test_reset();
    test_first_edge();
    test_frame();
    test_ce_toggle();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_VISIBLE, 800: active pixels per line.
REQ-002 Parameter H_FRONT, 40: horizontal front-porch pixels.
REQ-003 Parameter H_SYNC, 128: horizontal sync-pulse pixels.
REQ-004 Parameter H_BACK, 88: horizontal back-porch pixels.
REQ-005 Parameter V_VISIBLE, 600: active lines per frame.
REQ-006 Parameter V_FRONT, 1: vertical front-porch lines.
REQ-007 Parameter V_SYNC, 4: vertical sync-pulse lines.
REQ-008 Parameter V_BACK, 23: vertical back-porch lines.
REQ-009 Parameter HSYNC_POL, 1: hsync level while in horizontal sync region (1 = active-high).
REQ-010 Parameter VSYNC_POL, 1: vsync level while in vertical sync region.
REQ-011 Parameter HW, 11: hcount width; VW, 10: vcount width.
REQ-012 clk  input  1  single clock; all state changes on rising edge.
REQ-013 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-014 ce  input  1  pixel clock enable; counters advance only on clk edges with ce=1.
REQ-015 hcount  output  HW  current pixel column, 0..H_TOTAL-1.
REQ-016 vcount  output  VW  current line, 0..V_TOTAL-1.
REQ-017 h_visible_area, h_front_porch, h_sync_pulse, h_back_porch  output  1 each  horizontal region flags.
REQ-018 v_visible_area, v_front_porch, v_sync_pulse, v_back_porch  output  1 each  vertical region flags.
REQ-019 hsync, vsync  output  1 each  polarity-applied sync outputs.
REQ-020 de  output  1  display enable.
REQ-021 line_start, frame_start  output  1 each  single-cycle strobes.

Function
REQ-022 H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise; every region parameter SHALL be >=1, H_TOTAL <= 2^HW, V_TOTAL <= 2^VW (elaboration error otherwise).
REQ-023 On clk edge with ce=1: hcount SHALL increment by 1; at H_TOTAL-1 it SHALL wrap to 0.
REQ-024 vcount SHALL increment only on the ce edge where hcount wraps; at V_TOTAL-1 with hcount wrap, vcount SHALL wrap to 0.
REQ-025 With ce=0, hcount, vcount, region flags, hsync, vsync, de SHALL hold.
REQ-026 All outputs SHALL be registered and aligned: every flag describes the (hcount, vcount) presented in the same cycle (zero relative latency).
REQ-027 Horizontal regions: visible [0, H_VISIBLE-1], front [H_VISIBLE, +H_FRONT-1], sync next H_SYNC, back remaining H_BACK; vertical regions analogous on vcount.
REQ-028 Exactly one horizontal flag and exactly one vertical flag SHALL be 1 in every cycle (no overlap at boundaries).
REQ-029 hsync = HSYNC_POL when h_sync_pulse else ~HSYNC_POL; vsync = VSYNC_POL when v_sync_pulse else ~VSYNC_POL (vsync changes only at line boundaries).
REQ-030 de = h_visible_area AND v_visible_area.
REQ-031 line_start SHALL be 1 for exactly one clk cycle following the ce edge that sets hcount to 0; 0 otherwise, including while ce=0.
REQ-032 frame_start SHALL be 1 for exactly one clk cycle following the ce edge that sets hcount=0 and vcount=0; it implies line_start.
REQ-033 Counter arithmetic SHALL never exceed H_TOTAL-1/V_TOTAL-1; no intermediate overflow for any legal parameter set.

Reset
REQ-034 While reset=0 (asynchronously): hcount=H_TOTAL-1, vcount=V_TOTAL-1, h_back_porch=1, v_back_porch=1, other region flags 0, de=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, line_start=0, frame_start=0.
REQ-035 The first ce edge after reset release SHALL move to (0,0) with frame_start=1, line_start=1, de=1.
REQ-036 Reset asserted mid-frame SHALL immediately force the REQ-034 state; no partial line is resumed.

Verification (H 8/2/3/3, V 4/1/2/1, HW=4, VW=3, polarities 1 unless stated)
REQ-037 Release reset, ce=1 constant -> next cycle hcount=0, vcount=0, frame_start=1, de=1; frame_start recurs every 128 cycles.
REQ-038 Sweep one line -> h_visible 0..7, front 8..9, hsync=1 exactly at 10..12, back 13..15; vcount increments when hcount 15->0.
REQ-039 Full frame -> vsync=1 for vcount 5..6 only; de=1 count = 32; one-hot flag check every cycle.
REQ-040 ce toggled 1/0 alternately -> counters advance every 2 clks; line_start/frame_start width exactly 1 clk.
REQ-041 HSYNC_POL=0, VSYNC_POL=0 -> hsync=0 for hcount 10..12, vsync=0 for vcount 5..6; both 1 during reset.
REQ-042 Assert reset at (hcount=5, vcount=2) asynchronously between edges -> outputs take REQ-034 values before next edge; after release, restart at (0,0) with frame_start=1.
